// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID-side inputs, pipeline control, and the
// registered EX-side outputs that feed forwarding and the EX operand muxes.
interface id_ex_stage_if #(parameter int XLEN = 32);
  logic            d_valid;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_rs1data;
  logic [XLEN-1:0] d_rs2data;
  logic [XLEN-1:0] d_imm;
  logic [4:0]      d_rs1;
  logic [4:0]      d_rs2;
  logic [4:0]      d_rd;
  logic            d_rs1_used;
  logic            d_rs2_used;
  logic            d_regwrite;
  logic            d_memread;
  logic            d_memwrite;
  logic            d_alusrc;
  logic            d_branch;
  logic            d_jump;
  logic [3:0]      d_aluop;
  logic            ex_flush;
  logic            mem_busy;

  logic            stall;
  logic            e_valid;
  logic [XLEN-1:0] e_pc;
  logic [XLEN-1:0] e_rs1data;
  logic [XLEN-1:0] e_rs2data;
  logic [XLEN-1:0] e_imm;
  logic [4:0]      e_rs1;
  logic [4:0]      e_rs2;
  logic [4:0]      e_rd;
  logic            e_regwrite;
  logic            e_memread;
  logic            e_memwrite;
  logic            e_alusrc;
  logic            e_branch;
  logic            e_jump;
  logic [3:0]      e_aluop;
  logic [15:0]     stall_cnt;

  modport master (
    output d_valid, d_pc, d_rs1data, d_rs2data, d_imm, d_rs1, d_rs2, d_rd,
           d_rs1_used, d_rs2_used, d_regwrite, d_memread, d_memwrite,
           d_alusrc, d_branch, d_jump, d_aluop, ex_flush, mem_busy,
    input  stall, e_valid, e_pc, e_rs1data, e_rs2data, e_imm, e_rs1, e_rs2,
           e_rd, e_regwrite, e_memread, e_memwrite, e_alusrc, e_branch,
           e_jump, e_aluop, stall_cnt
  );

  modport slave (
    input  d_valid, d_pc, d_rs1data, d_rs2data, d_imm, d_rs1, d_rs2, d_rd,
           d_rs1_used, d_rs2_used, d_regwrite, d_memread, d_memwrite,
           d_alusrc, d_branch, d_jump, d_aluop, ex_flush, mem_busy,
    output stall, e_valid, e_pc, e_rs1data, e_rs2data, e_imm, e_rs1, e_rs2,
           e_rd, e_regwrite, e_memread, e_memwrite, e_alusrc, e_branch,
           e_jump, e_aluop, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch squash,
// deferred flush across memory freezes, and a saturating bubble counter.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1data;
    logic [XLEN-1:0] rs2data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            alusrc;
    logic            branch;
    logic            jump;
    logic [3:0]      aluop;
  } ex_regs_t;

  ex_regs_t    ex_q;
  ex_regs_t    id_next;
  logic        flush_pend;
  logic [15:0] stall_cnt_q;
  logic        hz;
  logic        rs1_match;
  logic        rs2_match;

  always_comb begin
    id_next          = '0;
    id_next.valid    = bus.d_valid;
    id_next.pc       = bus.d_pc;
    id_next.rs1data  = bus.d_rs1data;
    id_next.rs2data  = bus.d_rs2data;
    id_next.imm      = bus.d_imm;
    id_next.rs1      = bus.d_rs1;
    id_next.rs2      = bus.d_rs2;
    id_next.rd       = bus.d_rd;
    id_next.regwrite = bus.d_regwrite;
    id_next.memread  = bus.d_memread;
    id_next.memwrite = bus.d_memwrite;
    id_next.alusrc   = bus.d_alusrc;
    id_next.branch   = bus.d_branch;
    id_next.jump     = bus.d_jump;
    id_next.aluop    = bus.d_aluop;
  end

  // A load in EX whose result is read by the ID instruction; x0 is never a producer.
  always_comb begin
    rs1_match = bus.d_rs1_used && (bus.d_rs1 == ex_q.rd);
    rs2_match = bus.d_rs2_used && (bus.d_rs2 == ex_q.rd);
    hz = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) && bus.d_valid &&
         (rs1_match || rs2_match);
  end

  assign bus.stall = hz && !bus.ex_flush && !flush_pend;

  // Freeze beats flush beats hazard; a flush seen while frozen is replayed later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      flush_pend  <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else if (bus.mem_busy) begin
      if (bus.ex_flush) begin
        flush_pend <= 1'b1;
      end
    end else if (bus.ex_flush || flush_pend) begin
      ex_q       <= '0;
      flush_pend <= 1'b0;
    end else if (hz) begin
      ex_q <= '0;
      if (stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end else begin
      ex_q <= id_next;
    end
  end

  assign bus.e_valid    = ex_q.valid;
  assign bus.e_pc       = ex_q.pc;
  assign bus.e_rs1data  = ex_q.rs1data;
  assign bus.e_rs2data  = ex_q.rs2data;
  assign bus.e_imm      = ex_q.imm;
  assign bus.e_rs1      = ex_q.rs1;
  assign bus.e_rs2      = ex_q.rs2;
  assign bus.e_rd       = ex_q.rd;
  assign bus.e_regwrite = ex_q.regwrite;
  assign bus.e_memread  = ex_q.memread;
  assign bus.e_memwrite = ex_q.memwrite;
  assign bus.e_alusrc   = ex_q.alusrc;
  assign bus.e_branch   = ex_q.branch;
  assign bus.e_jump     = ex_q.jump;
  assign bus.e_aluop    = ex_q.aluop;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of two-instruction hazard vectors
// plus hand-written freeze, stall-release, saturation and async-reset sequences.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;

  id_ex_stage_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ld_memread;
    logic [4:0] ld_rd;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       flush;
    logic       exp_stall;
    logic       exp_e_valid;
    int         exp_inc;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveInstr(input logic valid, input logic [31:0] pc,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic rs1_used,
                            input logic rs2_used, input logic memread);
    bus.d_valid    = valid;
    bus.d_pc       = pc;
    bus.d_rs1data  = pc ^ 32'h5555_0000;
    bus.d_rs2data  = pc ^ 32'h0000_AAAA;
    bus.d_imm      = pc + 32'd16;
    bus.d_rs1      = rs1;
    bus.d_rs2      = rs2;
    bus.d_rd       = rd;
    bus.d_rs1_used = rs1_used;
    bus.d_rs2_used = rs2_used;
    bus.d_regwrite = 1'b1;
    bus.d_memread  = memread;
    bus.d_memwrite = 1'b0;
    bus.d_alusrc   = memread;
    bus.d_branch   = 1'b0;
    bus.d_jump     = 1'b0;
    bus.d_aluop    = pc[5:2];
  endtask

  // One load-use candidate pair: producer into EX, then consumer sits in ID.
  task automatic applyStimulus(input vec_t v);
    bus.ex_flush = 1'b0;
    bus.mem_busy = 1'b0;
    driveInstr(1'b1, 32'h100, 5'd0, 5'd0, v.ld_rd, 1'b0, 1'b0, v.ld_memread);
    tick();
    driveInstr(v.id_valid, 32'h104, v.id_rs1, v.id_rs2, 5'd9, v.rs1_used,
               v.rs2_used, 1'b0);
    bus.ex_flush = v.flush;
    #1;
    checkOutput({v.name, " stall"}, 32'(bus.stall), 32'(v.exp_stall));
    tick();
    bus.ex_flush = 1'b0;
    exp_cnt += v.exp_inc;
    checkOutput({v.name, " e_valid"}, 32'(bus.e_valid), 32'(v.exp_e_valid));
    checkOutput({v.name, " stall_cnt"}, 32'(bus.stall_cnt), 32'(exp_cnt));
    if (v.exp_e_valid) begin
      checkOutput({v.name, " e_pc"}, bus.e_pc, 32'h104);
      checkOutput({v.name, " e_rs1data"}, bus.e_rs1data, 32'h5555_0104);
    end
  endtask

  task automatic doHazard();
    driveInstr(1'b1, 32'h600, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
    tick();
    driveInstr(1'b1, 32'h604, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    vecs[0] = '{"lw_x5_rs1", 1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[1] = '{"lw_x0",     1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    vecs[2] = '{"sw_rs2",    1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[3] = '{"sw_norsu",  1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[4] = '{"flush_hz",  1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{"alu_prod",  1'b0, 5'd5, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[6] = '{"id_inval",  1'b1, 5'd5, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[7] = '{"lw_x7_rs2", 1'b1, 5'd7, 1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1};

    reset = 1'b1;
    bus.ex_flush = 1'b0;
    bus.mem_busy = 1'b0;
    driveInstr(1'b1, 32'h104, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
    #12;
    checkOutput("reset e_valid", 32'(bus.e_valid), 32'd0);
    checkOutput("reset e_pc", bus.e_pc, 32'd0);
    checkOutput("reset stall_cnt", 32'(bus.stall_cnt), 32'd0);
    checkOutput("reset stall", 32'(bus.stall), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    // Stall release: the held consumer enters EX on the edge after the bubble.
    driveInstr(1'b1, 32'h200, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
    tick();
    driveInstr(1'b1, 32'h204, 5'd5, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("release stall1", 32'(bus.stall), 32'd1);
    tick();
    exp_cnt++;
    checkOutput("release bubble", 32'(bus.e_valid), 32'd0);
    checkOutput("release stall0", 32'(bus.stall), 32'd0);
    tick();
    checkOutput("release e_valid", 32'(bus.e_valid), 32'd1);
    checkOutput("release e_pc", bus.e_pc, 32'h204);
    checkOutput("release e_rs1", 32'(bus.e_rs1), 32'd5);
    checkOutput("release cnt", 32'(bus.stall_cnt), 32'(exp_cnt));

    // Freeze for three edges with a flush in the first; flush lands afterwards.
    driveInstr(1'b1, 32'h300, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    driveInstr(1'b1, 32'h400, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0);
    bus.mem_busy = 1'b1;
    bus.ex_flush = 1'b1;
    tick();
    bus.ex_flush = 1'b0;
    checkOutput("busy1 e_pc", bus.e_pc, 32'h300);
    checkOutput("busy1 e_valid", 32'(bus.e_valid), 32'd1);
    tick();
    checkOutput("busy2 e_pc", bus.e_pc, 32'h300);
    tick();
    checkOutput("busy3 e_pc", bus.e_pc, 32'h300);
    checkOutput("busy3 e_rd", 32'(bus.e_rd), 32'd3);
    bus.mem_busy = 1'b0;
    tick();
    checkOutput("pend bubble", 32'(bus.e_valid), 32'd0);
    tick();
    checkOutput("after pend e_valid", 32'(bus.e_valid), 32'd1);
    checkOutput("after pend e_pc", bus.e_pc, 32'h400);
    checkOutput("busy cnt", 32'(bus.stall_cnt), 32'(exp_cnt));

    // Preload the counter close to the top so saturation needs few hazards.
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFD;
    for (int k = 0; k < 4; k++) begin
      doHazard();
      if (exp_cnt < 32'hFFFF) exp_cnt++;
      checkOutput("saturate", 32'(bus.stall_cnt), 32'(exp_cnt));
    end

    // Asynchronous reset in the middle of a load-use stall.
    driveInstr(1'b1, 32'h700, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
    tick();
    driveInstr(1'b1, 32'h704, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("pre-reset stall", 32'(bus.stall), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async stall_cnt", 32'(bus.stall_cnt), 32'd0);
    checkOutput("async e_valid", 32'(bus.e_valid), 32'd0);
    checkOutput("async stall", 32'(bus.stall), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    checkOutput("post-reset e_valid", 32'(bus.e_valid), 32'd1);
    checkOutput("post-reset e_pc", bus.e_pc, 32'h704);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the 5-stage pipelined RV32I core. It registers decoded operands and control from ID into EX and detects load-use hazards, inserting one bubble per hazard while stalling PC and IF/ID. It also squashes the ID/EX slot on a taken branch/jump and holds state on a memory freeze. Its e_rs1, e_rs2, e_rd, e_regwrite and e_alusrc outputs feed the forwarding unit and the EX operand muxes directly.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- d_valid  in  1  ID slot holds a real instruction
- d_pc  in  XLEN  PC of ID instruction
- d_rs1data, d_rs2data  in  XLEN  register-file read data
- d_imm  in  XLEN  decoded immediate
- d_rs1, d_rs2, d_rd  in  5  register indices
- d_rs1_used, d_rs2_used  in  1  instruction actually reads rs1 / rs2
- d_regwrite, d_memread, d_memwrite, d_alusrc, d_branch, d_jump  in  1  decoded control
- d_aluop  in  4  ALU operation
- ex_flush  in  1  taken branch/jump resolved in EX this cycle
- mem_busy  in  1  data memory not ready; freeze whole pipe
- stall  out  1  combinational; hold PC and IF/ID this cycle
- e_valid  out  1  EX slot valid
- e_pc, e_rs1data, e_rs2data, e_imm  out  XLEN  registered copies
- e_rs1, e_rs2, e_rd  out  5  registered indices
- e_regwrite, e_memread, e_memwrite, e_alusrc, e_branch, e_jump  out  1  registered control
- e_aluop  out  4  registered ALU op
- stall_cnt  out  16  saturating count of load-use bubbles inserted

## Operation
- Load-use hazard (hz) = e_valid & e_memread & (e_rd != 0) & d_valid & ((d_rs1_used & d_rs1 == e_rd) | (d_rs2_used & d_rs2 == e_rd)).
- stall = hz & ~ex_flush & ~flush_pend. A flush overrides the hazard: the ID instruction is itself squashed.
- Bubble load: e_valid, e_regwrite, e_memread, e_memwrite, e_branch, e_jump <= 0. Data/index fields are don't-care but are cleared to 0 for determinism.
- Per-edge priority, highest first:
  1. mem_busy: all e_* hold. If ex_flush is also high, set flush_pend.
  2. ex_flush | flush_pend: bubble load, clear flush_pend.
  3. hz: bubble load, stall_cnt += 1 (saturates at 0xFFFF).
  4. otherwise: load every d_* into e_*, with e_valid <= d_valid.
- During mem_busy, stall still evaluates combinationally. The upstream freeze is owned by mem_busy, so no double-count occurs: stall_cnt increments only on a bubble-load edge.
- d_valid = 0 with no other condition loads a bubble-equivalent (e_valid = 0). Control bits are copied as-is, and EX gates them with e_valid.
- rd = x0 never raises a hazard.

## Timing
- Reset (async, immediate): all e_* = 0, flush_pend = 0, stall_cnt = 0. stall is therefore 0 while reset is held.
- Latency ID→EX: 1 cycle.
- A load-use stall lasts exactly 1 cycle. After the bubble, e_memread = 0, so hz falls. The dependent instruction enters EX one cycle later and is forwarded from MEM/WB.
- ex_flush is sampled on the same edge as the EX instruction's retirement into MEM. The bubble replaces the wrong-path ID instruction on that edge.
- A flush arriving during mem_busy is deferred via flush_pend and applied on the first edge with mem_busy = 0.
- Reset asserted mid-stall or mid-freeze clears all state. The first post-reset edge follows rule 4.

## Test plan
- lw x5 in EX (e_memread = 1, e_rd = 5), ID add reads x5 via rs1 → stall = 1 for one cycle, e_valid = 0 next edge, stall_cnt = 1; the following edge loads add with stall = 0.
- lw x0 in EX, ID reads x0 → stall = 0, no bubble, stall_cnt unchanged.
- ID sw with d_rs2 = 5, d_rs2_used = 1, d_rs1_used = 0 behind lw x5 → stall = 1. Same with d_rs2_used = 0 → stall = 0.
- ex_flush = 1 together with a load-use hz → stall = 0, next e_valid = 0, stall_cnt unchanged.
- mem_busy = 1 for 3 cycles, ex_flush pulsed in cycle 1 → e_* hold for 3 edges; the first free edge loads a bubble; the next edge loads the ID instruction.
- Drive 70000 consecutive hazards → stall_cnt saturates at 0xFFFF. Assert reset asynchronously mid-run → stall_cnt = 0 and e_valid = 0 immediately, without waiting for a clock edge.
